// File: rtl/reflet_mailbox_pkg.sv
// Shared definitions for the reflet mailbox: register offsets and STATUS bit layout.
package reflet_mailbox_pkg;

  // Register offsets within the four-register window (addr[1:0]).
  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_RX_DATA = 2'd1,
    REG_RX_POP  = 2'd2,
    REG_TX_DATA = 2'd3
  } reg_off_e;

  // STATUS register bit positions; bits 7..5 always read 0.
  localparam int ST_RX_NONEMPTY = 0;
  localparam int ST_RX_FULL     = 1;
  localparam int ST_TX_EMPTY    = 2;
  localparam int ST_TX_FULL     = 3;
  localparam int ST_RX_OVERFLOW = 4;

endpackage : reflet_mailbox_pkg

// File: rtl/reflet_mailbox_fifo.sv
// Synchronous FIFO with occupancy counter; used for both mailbox directions.
// A push while full is dropped even if a pop happens in the same cycle.
module reflet_mailbox_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;

  // Occupancy next-state: simultaneous push and pop leave the count unchanged.
  always_comb begin
    // NOTE: default assignment first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointers and counter; pointers are AW bits wide and wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage array write port.
  // NOTE: the array has no reset; head is forced to 0 while empty so stale entries never show.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule : reflet_mailbox_fifo

// File: rtl/reflet_mailbox.sv
// CPU <-> host mailbox on the reflet system bus: RX (host->CPU) and TX (CPU->host)
// FIFOs, a sticky RX overflow flag and a level irq while RX holds data.
module reflet_mailbox
  import reflet_mailbox_pkg::*;
#(
  parameter int                        wordsize       = 16,
  parameter int                        base_addr_size = wordsize - 1,
  parameter logic [base_addr_size-1:0] base_addr      = base_addr_size'('h7F20),
  parameter int                        depth          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic [7:0]                data_in,
  output logic [7:0]                data_out,
  input  logic                      write_en,
  output logic                      irq,
  input  logic [7:0]                host_in_data,
  input  logic                      host_in_valid,
  output logic                      host_in_ready,
  output logic [7:0]                host_out_data,
  output logic                      host_out_valid,
  input  logic                      host_out_ready
);

  localparam int CNT_W = $clog2(depth) + 1;

  logic             sel, wr_q, wr_pulse;
  reg_off_e         off;
  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]       rx_head, tx_head, status;
  logic [CNT_W-1:0] rx_count, tx_count;
  logic             ovf_q, ovf_d, ovf_set, ovf_clr;

  assign sel      = enable & (addr[base_addr_size-1:2] == base_addr[base_addr_size-1:2]);
  assign off      = reg_off_e'(addr[1:0]);
  // A held write strobe acts only on its first cycle.
  assign wr_pulse = sel & write_en & ~wr_q;

  assign rx_push = host_in_valid & ~rx_full;
  assign rx_pop  = wr_pulse & (off == REG_RX_POP);
  assign tx_push = wr_pulse & (off == REG_TX_DATA);
  assign tx_pop  = ~tx_empty & host_out_ready;

  assign ovf_set = host_in_valid & rx_full;
  assign ovf_clr = wr_pulse & (off == REG_STATUS) & data_in[ST_RX_OVERFLOW];

  reflet_mailbox_fifo #(.WIDTH(8), .DEPTH(depth)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (host_in_data),
    .pop       (rx_pop),
    .full      (rx_full),
    .empty     (rx_empty),
    .head      (rx_head),
    .count     (rx_count)
  );

  reflet_mailbox_fifo #(.WIDTH(8), .DEPTH(depth)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (data_in),
    .pop       (tx_pop),
    .full      (tx_full),
    .empty     (tx_empty),
    .head      (tx_head),
    .count     (tx_count)
  );

  // Overflow next-state: a new overflow event beats a same-cycle software clear.
  always_comb begin
    ovf_d = ovf_set | (ovf_q & ~ovf_clr);
  end

  // Write-edge detector and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= sel & write_en;
      ovf_q <= ovf_d;
    end
  end

  // STATUS register image.
  always_comb begin
    status                 = '0;
    status[ST_RX_NONEMPTY] = ~rx_empty;
    status[ST_RX_FULL]     = rx_full;
    status[ST_TX_EMPTY]    = tx_empty;
    status[ST_TX_FULL]     = tx_full;
    status[ST_RX_OVERFLOW] = ovf_q;
  end

  // Read mux; drives 0 when not addressed because the bus is OR-combined.
  always_comb begin
    data_out = '0;
    if (sel) begin
      case (off)
        REG_STATUS:  data_out = status;
        REG_RX_DATA: data_out = rx_head;
        default:     data_out = '0;
      endcase
    end
  end

  assign irq            = ~rx_empty;
  assign host_in_ready  = ~rx_full;
  assign host_out_valid = ~tx_empty;
  assign host_out_data  = tx_head;

  // FIFO flags must agree with their occupancy counters.
  a_rx_flags : assert property (@(posedge clk) disable iff (!reset)
    (rx_full == (rx_count == CNT_W'(depth))) && (rx_empty == (rx_count == '0)));
  a_tx_flags : assert property (@(posedge clk) disable iff (!reset)
    (tx_full == (tx_count == CNT_W'(depth))) && (tx_empty == (tx_count == '0)));

endmodule : reflet_mailbox

// File: tb/tb_reflet_mailbox.sv
// Scoreboard bench for reflet_mailbox: stimulus tasks update a queue-based model,
// a negedge monitor compares DUT outputs, TX stream bytes and bus reads.
module tb_reflet_mailbox;

  localparam int          D    = 8;
  localparam logic [14:0] BASE = 15'h7F20;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, write_en, host_in_valid, host_out_ready;
  logic [14:0] addr;
  logic [7:0]  data_in, host_in_data;
  logic [7:0]  data_out, host_out_data;
  logic        irq, host_in_ready, host_out_valid;

  // Reference model state.
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] rd_exp[$];
  logic       ovf;
  logic       rd_req;
  logic       chk_en;

  int n_checks = 0;
  int n_fail   = 0;

  reflet_mailbox #(
    .wordsize(16), .base_addr_size(15), .base_addr(BASE), .depth(D)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .addr           (addr),
    .data_in        (data_in),
    .data_out       (data_out),
    .write_en       (write_en),
    .irq            (irq),
    .host_in_data   (host_in_data),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .host_out_data  (host_out_data),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] a_of(input logic [1:0] o);
    return {BASE[14:2], o};
  endfunction

  function automatic logic [7:0] model_status();
    logic [7:0] s;
    s    = '0;
    s[0] = rx_q.size() != 0;
    s[1] = rx_q.size() == D;
    s[2] = tx_q.size() == 0;
    s[3] = tx_q.size() == D;
    s[4] = ovf;
    return s;
  endfunction

  // Host offers one byte for one cycle; rejected (and flagged) when RX is full.
  task automatic host_push(input logic [7:0] b);
    logic ok;
    ok = rx_q.size() < D;
    host_in_data  = b;
    host_in_valid = 1'b1;
    cycle();
    if (ok) rx_q.push_back(b);
    else    ovf = 1'b1;
    host_in_valid = 1'b0;
  endtask

  // Bus write with the strobe held for 'hold' cycles; acts once if addressed.
  task automatic cpu_write(input logic en, input logic [14:0] a, input logic [7:0] d, input int hold);
    logic hit, tx_ok, rx_ok;
    hit   = en && (a[14:2] == BASE[14:2]);
    tx_ok = tx_q.size() < D;
    rx_ok = rx_q.size() != 0;
    enable = en; addr = a; data_in = d; write_en = 1'b1;
    cycle();
    if (hit) begin
      case (a[1:0])
        2'd0: if (d[4]) ovf = 1'b0;
        2'd2: if (rx_ok) void'(rx_q.pop_front());
        2'd3: if (tx_ok) tx_q.push_back(d);
        default: ;
      endcase
    end
    repeat (hold - 1) cycle();
    write_en = 1'b0; enable = 1'b0;
    cycle();
  endtask

  // Bus read: the expected value goes to the scoreboard, the monitor compares.
  task automatic cpu_read(input logic en, input logic [14:0] a);
    logic [7:0] e;
    e = '0;
    if (en && (a[14:2] == BASE[14:2])) begin
      if (a[1:0] == 2'd0) e = model_status();
      else if (a[1:0] == 2'd1) e = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    end
    enable = en; addr = a; write_en = 1'b0;
    rd_exp.push_back(e);
    rd_req = 1'b1;
    cycle();
    enable = 1'b0;
  endtask

  task automatic drain(input int n);
    host_out_ready = 1'b1;
    repeat (n) cycle();
    host_out_ready = 1'b0;
  endtask

  // Monitor: stream outputs, TX handshakes and pending bus reads.
  always @(negedge clk) begin
    if (chk_en) begin
      check("irq", irq, rx_q.size() != 0);
      check("host_in_ready", host_in_ready, rx_q.size() < D);
      check("host_out_valid", host_out_valid, tx_q.size() != 0);
      check("host_out_data", host_out_data, (tx_q.size() != 0) ? tx_q[0] : 8'h00);
      if (host_out_valid && host_out_ready && tx_q.size() != 0) begin
        check("tx_byte", host_out_data, tx_q.pop_front());
      end
      if (rd_req) begin
        check("rd_data", data_out, rd_exp.pop_front());
        rd_req = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; write_en = 1'b0; addr = '0; data_in = '0;
    host_in_valid = 1'b0; host_in_data = '0; host_out_ready = 1'b0;
    ovf = 1'b0; rd_req = 1'b0; chk_en = 1'b0;
    #1 reset = 1'b0;
    repeat (2) cycle();
    chk_en = 1'b1;
    cycle();
    reset = 1'b1;
    cycle();

    // Reset state and unselected reads.
    cpu_read(1'b1, a_of(2'd0));
    for (int o = 0; o < 4; o++) cpu_read(1'b0, a_of(2'(o)));

    // Host -> CPU basic flow.
    host_push(8'hA5);
    host_push(8'h3C);
    cpu_read(1'b1, a_of(2'd0));
    cpu_read(1'b1, a_of(2'd1));
    cpu_write(1'b1, a_of(2'd2), 8'h00, 1);
    cpu_read(1'b1, a_of(2'd1));
    cpu_write(1'b1, a_of(2'd2), 8'h00, 1);
    cpu_read(1'b1, a_of(2'd0));
    cpu_write(1'b1, a_of(2'd2), 8'h00, 1);
    cpu_read(1'b1, a_of(2'd2));
    cpu_read(1'b1, a_of(2'd3));

    // CPU -> host basic flow.
    cpu_write(1'b1, a_of(2'd3), 8'h11, 1);
    cpu_write(1'b1, a_of(2'd3), 8'h22, 1);
    repeat (2) cycle();
    drain(2);
    cycle();

    // Strobe held five cycles pushes once.
    cpu_write(1'b1, a_of(2'd3), 8'h5A, 5);
    cpu_read(1'b1, a_of(2'd0));
    drain(3);

    // RX full, overflow, set-wins-over-clear, then read back all contents.
    for (int i = 0; i < D; i++) host_push(8'(8'h40 + i));
    cpu_read(1'b1, a_of(2'd0));
    host_push(8'h99);
    cpu_read(1'b1, a_of(2'd0));
    cpu_read(1'b1, a_of(2'd1));
    cpu_write(1'b1, a_of(2'd0), 8'h10, 1);
    cpu_read(1'b1, a_of(2'd0));
    host_in_valid = 1'b1; host_in_data = 8'h77;
    enable = 1'b1; addr = a_of(2'd0); data_in = 8'h10; write_en = 1'b1;
    cycle();
    ovf = 1'b1;
    host_in_valid = 1'b0; write_en = 1'b0; enable = 1'b0;
    cycle();
    cpu_read(1'b1, a_of(2'd0));
    cpu_write(1'b1, a_of(2'd0), 8'h10, 1);
    for (int i = 0; i < D; i++) begin
      cpu_read(1'b1, a_of(2'd1));
      cpu_write(1'b1, a_of(2'd2), 8'h00, 1);
    end
    cpu_read(1'b1, a_of(2'd0));

    // TX full: ninth byte dropped, then pop-while-full drops the push too.
    for (int i = 0; i < D; i++) cpu_write(1'b1, a_of(2'd3), 8'(8'hC0 + i), 1);
    cpu_read(1'b1, a_of(2'd0));
    cpu_write(1'b1, a_of(2'd3), 8'hFF, 1);
    host_out_ready = 1'b1;
    cpu_write(1'b1, a_of(2'd3), 8'hEE, 1);
    drain(D);
    cycle();

    // Reset asserted mid-drain discards everything.
    for (int i = 0; i < D; i++) cpu_write(1'b1, a_of(2'd3), 8'(8'h80 + i), 1);
    host_push(8'h12);
    host_out_ready = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    rx_q.delete(); tx_q.delete(); ovf = 1'b0;
    repeat (2) cycle();
    reset = 1'b1;
    host_out_ready = 1'b0;
    cycle();
    cpu_read(1'b1, a_of(2'd0));

    // Randomised mix of all bus and host operations.
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: host_push(8'($urandom));
        3: cpu_read(1'b1, a_of(2'($urandom_range(0, 3))));
        4: cpu_read(1'($urandom_range(0, 1)),
                    {BASE[14:2] ^ 13'(1 << $urandom_range(0, 12)), 2'($urandom_range(0, 3))});
        5: cpu_write(1'b1, a_of(2'd2), 8'($urandom), $urandom_range(1, 3));
        6: cpu_write(1'b1, a_of(2'd3), 8'($urandom), $urandom_range(1, 3));
        7: cpu_write(1'b1, a_of(2'd0), 8'($urandom), 1);
        8: drain($urandom_range(1, 4));
        default: cpu_write(1'($urandom_range(0, 1)),
                           {BASE[14:2] ^ 13'(1 << $urandom_range(0, 12)), 2'($urandom_range(0, 3))},
                           8'($urandom), 1);
      endcase
    end
    drain(D + 1);
    cpu_read(1'b1, a_of(2'd0));
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_reflet_mailbox
